morse_rx_timed: RTL and testbench
=================================

// Module: morse_rx_timed
// PURPOSE
//  Parametrised successor to the morse receiver; sits between the button debouncer and the char decoder/UART.
//  Internal unit timers replace the four external timeout inputs and their reset outputs.
//  Classifies press durations as dot/dash and assembles up to MAX_SYMBOLS symbols per character.
//  Emits characters on a valid/ready handshake, plus word-gap pulses and error reports.
// PARAMETERS
//  TICK_DIV       2_500_000  clk cycles per Morse time unit (25 ms at 100 MHz)
//  MAX_SYMBOLS    6          max dots/dashes per character
//  DOT_MAX_UNITS  2          press < this many units = dot; >= = dash
//  CHAR_GAP_UNITS 3          release gap (units) that closes a character
//  WORD_GAP_UNITS 7          release gap (units) that signals a word space; must be > CHAR_GAP_UNITS
//  BTN_TO_UNITS   20         held press that reaches this count = stuck button; must be > DOT_MAX_UNITS
// PORTS
//  clk_100MHz  in   1              system clock
//  reset_n     in   1              async active-low reset
//  user_btn    in   1              debounced button level, synchronous to clk_100MHz
//  char_sym    out  MAX_SYMBOLS    symbols, bit0 = first; 0 = dot, 1 = dash; unused bits 0
//  char_len    out  $clog2(MAX_SYMBOLS+1)  number of valid symbols (1..MAX_SYMBOLS)
//  char_valid  out  1              char_sym/char_len valid; held until accepted
//  char_ready  in   1              consumer accepts when char_valid && char_ready
//  word_valid  out  1              1-cycle pulse when the word gap elapses
//  err_valid   out  1              1-cycle pulse on error
//  err_code    out  2              0 none, 1 OVERFLOW, 2 STUCK, 3 DROP; valid with err_valid, else 0
// BEHAVIOUR
//  - Reset (async, any time incl. mid-char): all outputs 0, buffer/len/counters 0, state IDLE.
//  - Timer: tick_cnt counts 0..TICK_DIV-1 and raises tick on wrap; unit_cnt increments per tick and saturates.
//    Both counters clear on every user_btn edge (rise/fall detected via a registered copy of user_btn).
//  - FSM states: IDLE, PRESS, GAP, WORD, ABORT.
//    IDLE:  btn rise -> PRESS.
//    PRESS: unit_cnt reaches BTN_TO_UNITS -> err STUCK, clear buffer -> ABORT.
//           Fall with sym_len == MAX_SYMBOLS -> err OVERFLOW, clear buffer -> IDLE.
//           Other fall -> store (unit_cnt >= DOT_MAX_UNITS) at bit sym_len, sym_len++ -> GAP.
//    GAP:   rise before unit_cnt == CHAR_GAP_UNITS -> PRESS (same char).
//           unit_cnt == CHAR_GAP_UNITS -> emit char, clear buffer -> WORD (counters not cleared).
//           A rise in the same cycle still emits; the next state is then PRESS.
//    WORD:  rise -> PRESS (new char).
//           unit_cnt == WORD_GAP_UNITS -> word_valid pulse -> IDLE.
//    ABORT: wait for fall -> IDLE. No symbol stored, no word_valid.
//  - Emit: the output register loads sym/len and sets char_valid the cycle after the gap is detected.
//    If char_valid && !char_ready at emit: new char dropped, old kept, err DROP.
//    If char_ready and emit coincide: old char accepted and new loaded in the same cycle; char_valid stays 1.
//  - Latency: char_valid rises CHAR_GAP_UNITS*TICK_DIV+1 cycles after the releasing fall.
//  - err_valid/err_code and word_valid are single-cycle registered pulses; at most one error per cycle.
// STRUCTURE
//  - morse_pkg: state_t enum, err_code_t enum (ERR_NONE/OVERFLOW/STUCK/DROP), symbol encoding constants.
//  - Sub-module morse_unit_timer: prescaler + saturating unit counter; clear input; outputs tick and unit_cnt.
//    Instantiated once.
//  - Top level: edge detect, FSM, symbol shift buffer, output register/handshake, error/word pulse registers.
// TESTING (bench params: TICK_DIV=4, MAX_SYMBOLS=6, DOT_MAX=2, CHAR_GAP=3, WORD_GAP=7, BTN_TO=10; char_ready=1 unless noted)
//  1. Press 4 cyc, gap 8 cyc, press 12 cyc, release 40 cyc ->
//     char_len=2, char_sym=6'b000010 ('A'), one char_valid, then one word_valid.
//  2. Six 4-cyc dots, then a seventh press/release -> err OVERFLOW pulse, no char_valid, FSM IDLE.
//  3. Hold 45 cyc -> err STUCK at unit 10; release -> IDLE; no char, no word_valid.
//  4. char_ready=0; send 'E' then 'T' -> char_valid held with len 1/sym 0; second emit gives err DROP;
//     raise ready -> 'E' accepted.
//  5. Assert reset_n=0 mid-press and mid-gap -> all outputs 0 immediately.
//     After release, a fresh 'E' decodes correctly.
//  6. Rise exactly on the CHAR_GAP unit -> previous char emitted and new press tracked into a separate char.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared types for the timed Morse receiver: FSM states, error codes and
// the symbol encoding.
package morse_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRESS,
      S_GAP,
      S_WORD,
      S_ABORT
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'd0,
      ERR_OVERFLOW = 2'd1,
      ERR_STUCK    = 2'd2,
      ERR_DROP     = 2'd3
   } err_code_t;

   localparam logic SYM_DOT  = 1'b0;
   localparam logic SYM_DASH = 1'b1;

endpackage

// File: rtl/morse_unit_timer.sv
// Prescaler plus saturating Morse-unit counter, both cleared by any
// button edge so unit_cnt always measures the current press or gap.
module morse_unit_timer #(
   parameter int TICK_DIV = 2_500_000,
   parameter int UNIT_W   = 5
) (
   input  logic              clk_100MHz,
   input  logic              reset_n,
   input  logic              clear,
   output logic              tick,
   output logic [UNIT_W-1:0] unit_cnt
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   logic [TW-1:0] tick_cnt;

   assign tick = !clear && (tick_cnt == TICK_LAST);

   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         tick_cnt <= '0;
         unit_cnt <= '0;
      end else if (clear) begin
         tick_cnt <= '0;
         unit_cnt <= '0;
      end else begin
         if (tick) tick_cnt <= '0;
         else      tick_cnt <= tick_cnt + 1'b1;
         if (tick && unit_cnt != '1)
            unit_cnt <= unit_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/morse_rx_timed.sv
// Morse receiver: times presses/gaps in units, assembles symbols into a
// character and hands it out on valid/ready with word and error pulses.
module morse_rx_timed
   import morse_pkg::*;
#(
   parameter int TICK_DIV       = 2_500_000,
   parameter int MAX_SYMBOLS    = 6,
   parameter int DOT_MAX_UNITS  = 2,
   parameter int CHAR_GAP_UNITS = 3,
   parameter int WORD_GAP_UNITS = 7,
   parameter int BTN_TO_UNITS   = 20,
   localparam int LEN_W = $clog2(MAX_SYMBOLS + 1)
) (
   input  logic                   clk_100MHz,
   input  logic                   reset_n,
   input  logic                   user_btn,
   output logic [MAX_SYMBOLS-1:0] char_sym,
   output logic [LEN_W-1:0]       char_len,
   output logic                   char_valid,
   input  logic                   char_ready,
   output logic                   word_valid,
   output logic                   err_valid,
   output logic [1:0]             err_code
);

   localparam int UNIT_MAX = (BTN_TO_UNITS > WORD_GAP_UNITS) ?
                             BTN_TO_UNITS : WORD_GAP_UNITS;
   localparam int UNIT_W   = $clog2(UNIT_MAX + 1);

   state_t                 state;
   err_code_t              err_q;
   logic                   btn_q;
   logic [MAX_SYMBOLS-1:0] sym_buf;
   logic [LEN_W-1:0]       sym_len;
   logic                   tick;
   logic [UNIT_W-1:0]      unit_cnt;

   logic rise, fall, btn_edge;
   logic stuck, gap_hit, word_hit, is_dash, buf_full, hold_old;

   assign rise     = user_btn & ~btn_q;
   assign fall     = ~user_btn & btn_q;
   assign btn_edge = user_btn ^ btn_q;

   morse_unit_timer #(
      .TICK_DIV (TICK_DIV),
      .UNIT_W   (UNIT_W)
   ) u_timer (
      .clk_100MHz (clk_100MHz),
      .reset_n    (reset_n),
      .clear      (btn_edge),
      .tick       (tick),
      .unit_cnt   (unit_cnt)
   );

   // Stuck fires on the tick that carries unit_cnt onto the timeout;
   // a release in that cycle suppresses the tick and wins.
   assign stuck    = tick && (unit_cnt == UNIT_W'(BTN_TO_UNITS - 1));
   assign gap_hit  = (unit_cnt == UNIT_W'(CHAR_GAP_UNITS));
   assign word_hit = (unit_cnt == UNIT_W'(WORD_GAP_UNITS));
   assign is_dash  = (unit_cnt >= UNIT_W'(DOT_MAX_UNITS));
   assign buf_full = (sym_len == LEN_W'(MAX_SYMBOLS));
   assign hold_old = char_valid && !char_ready;
   assign err_code = err_q;

   always_ff @(posedge clk_100MHz or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         btn_q      <= 1'b0;
         sym_buf    <= '0;
         sym_len    <= '0;
         char_sym   <= '0;
         char_len   <= '0;
         char_valid <= 1'b0;
         word_valid <= 1'b0;
         err_valid  <= 1'b0;
         err_q      <= ERR_NONE;
      end else begin
         btn_q      <= user_btn;
         word_valid <= 1'b0;
         err_valid  <= 1'b0;
         err_q      <= ERR_NONE;
         if (char_valid && char_ready)
            char_valid <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (rise) state <= S_PRESS;
            end
            S_PRESS: begin
               if (stuck) begin
                  err_valid <= 1'b1;
                  err_q     <= ERR_STUCK;
                  sym_buf   <= '0;
                  sym_len   <= '0;
                  state     <= S_ABORT;
               end else if (fall && buf_full) begin
                  err_valid <= 1'b1;
                  err_q     <= ERR_OVERFLOW;
                  sym_buf   <= '0;
                  sym_len   <= '0;
                  state     <= S_IDLE;
               end else if (fall) begin
                  sym_buf <= sym_buf |
                             (MAX_SYMBOLS'(is_dash) << sym_len);
                  sym_len <= sym_len + 1'b1;
                  state   <= S_GAP;
               end
            end
            S_GAP: begin
               if (gap_hit) begin
                  if (hold_old) begin
                     err_valid <= 1'b1;
                     err_q     <= ERR_DROP;
                  end else begin
                     char_sym   <= sym_buf;
                     char_len   <= sym_len;
                     char_valid <= 1'b1;
                  end
                  sym_buf <= '0;
                  sym_len <= '0;
                  state   <= rise ? S_PRESS : S_WORD;
               end else if (rise) begin
                  state <= S_PRESS;
               end
            end
            S_WORD: begin
               if (rise) begin
                  state <= S_PRESS;
               end else if (word_hit) begin
                  word_valid <= 1'b1;
                  state      <= S_IDLE;
               end
            end
            S_ABORT: begin
               if (fall) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_morse_rx_timed.sv
// Directed bench for morse_rx_timed: scoreboard queues for characters and
// errors, drained by a negedge monitor as the DUT produces them.
module tb_morse_rx_timed;

   localparam int TD = 4;
   localparam int MS = 6;
   localparam int CG = 3;
   localparam int LAT = CG * TD + 1;

   typedef struct {
      logic [2:0] len;
      logic [5:0] sym;
   } ch_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       user_btn = 1'b0;
   logic       char_ready = 1'b1;
   logic [5:0] char_sym;
   logic [2:0] char_len;
   logic       char_valid;
   logic       word_valid;
   logic       err_valid;
   logic [1:0] err_code;

   ch_t        exp_q[$];
   logic [1:0] exp_err[$];
   int total = 0;
   int passed = 0;
   int failed = 0;
   int got_chars = 0;
   int got_words = 0;
   int exp_chars = 0;
   int exp_words = 0;

   morse_rx_timed #(
      .TICK_DIV       (TD),
      .MAX_SYMBOLS    (MS),
      .DOT_MAX_UNITS  (2),
      .CHAR_GAP_UNITS (CG),
      .WORD_GAP_UNITS (7),
      .BTN_TO_UNITS   (10)
   ) dut (
      .clk_100MHz (clk),
      .reset_n    (reset_n),
      .user_btn   (user_btn),
      .char_sym   (char_sym),
      .char_len   (char_len),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .word_valid (word_valid),
      .err_valid  (err_valid),
      .err_code   (err_code)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic level(input logic v, input int n);
      user_btn = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic push_char(input int len, input int sym);
      ch_t c;
      c.len = 3'(len);
      c.sym = 6'(sym);
      exp_q.push_back(c);
      exp_chars++;
   endtask

   task automatic chk_zero(input string t);
      chk({t, "_cvalid"}, 32'(char_valid), 0);
      chk({t, "_clen"},   32'(char_len), 0);
      chk({t, "_csym"},   32'(char_sym), 0);
      chk({t, "_wvalid"}, 32'(word_valid), 0);
      chk({t, "_evalid"}, 32'(err_valid), 0);
      chk({t, "_ecode"},  32'(err_code), 0);
   endtask

   task automatic end_test(input string t);
      chk({t, "_chars"},     got_chars, exp_chars);
      chk({t, "_words"},     got_words, exp_words);
      chk({t, "_chars_left"}, exp_q.size(), 0);
      chk({t, "_errs_left"}, exp_err.size(), 0);
   endtask

   // Release already driven; count edges from the one sampling the fall.
   task automatic wait_char(input string t, output int n);
      n = 0;
      while (!char_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({t, "_latency"}, n - 1, LAT);
   endtask

   always @(negedge clk) begin
      if (reset_n) begin
         if (char_valid && char_ready) begin
            got_chars++;
            chk("char_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               ch_t e;
               e = exp_q.pop_front();
               chk("char_len", 32'(char_len), 32'(e.len));
               chk("char_sym", 32'(char_sym), 32'(e.sym));
            end
         end
         if (err_valid) begin
            chk("err_expected", 32'(exp_err.size() != 0), 1);
            if (exp_err.size() != 0)
               chk("err_code", 32'(err_code), 32'(exp_err.pop_front()));
         end
         if (word_valid) got_words++;
      end
   end

   initial begin
      int n;
      #1;
      chk_zero("reset");
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      level(1'b0, 10);

      // 'A': dot, dash
      push_char(2, 6'b000010);
      exp_words++;
      level(1'b1, 4);
      level(1'b0, 8);
      level(1'b1, 12);
      user_btn = 1'b0;
      wait_char("t1", n);
      level(1'b0, 40 - n);
      end_test("t1");

      // seven symbols overflow the buffer
      exp_err.push_back(2'd1);
      repeat (MS) begin
         level(1'b1, 4);
         level(1'b0, 4);
      end
      level(1'b1, 4);
      level(1'b0, 30);
      end_test("t2");

      // stuck button
      exp_err.push_back(2'd2);
      level(1'b1, 45);
      level(1'b0, 30);
      end_test("t3");

      // consumer stalled: 'E' held, 'T' dropped
      char_ready = 1'b0;
      push_char(1, 0);
      exp_err.push_back(2'd3);
      exp_words++;
      level(1'b1, 4);
      user_btn = 1'b0;
      wait_char("t4", n);
      chk("t4_hold_valid", 32'(char_valid), 1);
      chk("t4_hold_len", 32'(char_len), 1);
      chk("t4_hold_sym", 32'(char_sym), 0);
      level(1'b0, 20 - n);
      level(1'b1, 12);
      level(1'b0, 40);
      chk("t4_kept_valid", 32'(char_valid), 1);
      chk("t4_kept_len", 32'(char_len), 1);
      chk("t4_kept_sym", 32'(char_sym), 0);
      char_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("t4_accepted", 32'(char_valid), 0);
      end_test("t4");

      // reset mid-press with a char held, then mid-gap
      char_ready = 1'b0;
      level(1'b1, 4);
      level(1'b0, 16);
      chk("t5_held", 32'(char_valid), 1);
      level(1'b1, 3);
      #2 reset_n = 1'b0;
      #1 chk_zero("t5_press");
      user_btn = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      char_ready = 1'b1;
      level(1'b1, 4);
      level(1'b0, 6);
      #2 reset_n = 1'b0;
      #1 chk_zero("t5_gap");
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      push_char(1, 0);
      exp_words++;
      level(1'b1, 4);
      level(1'b0, 40);
      end_test("t5");

      // rise on the char-gap unit splits 'T' from the following 'E'
      push_char(1, 6'b000001);
      push_char(1, 0);
      exp_words++;
      level(1'b1, 12);
      level(1'b0, CG * TD + 1);
      level(1'b1, 4);
      level(1'b0, 40);
      end_test("t6");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
